// File: rtl/shop_seq_pkg.sv
// shop_seq_pkg: shared types and constants for the shop_v sequencer
package shop_seq_pkg;
  typedef enum logic [1:0] {FILL, DRIVE, OUT} state_t;
  localparam logic [1:0] SLOT_LO = 2'd0;
  localparam logic [1:0] SLOT_MID = 2'd1;
  localparam logic [1:0] SLOT_HI = 2'd2;
  localparam logic [7:0] PAD_DEFAULT = 8'h20;
  localparam int MODE_A = 0;
  localparam int MODE_B = 1;
  localparam int MODE_C = 2;
endpackage

// File: rtl/shop_seq_ctrl_if.sv
// shop_seq_ctrl_if: byte stream in, shop_v drive/return, result word out
interface shop_seq_ctrl_if #(parameter int CNT_W = 16);
  logic [2:0] i_mode;
  logic [7:0] i_byte;
  logic i_byte_valid;
  logic i_last;
  logic o_byte_ready;
  logic o_dp_a;
  logic o_dp_b;
  logic o_dp_c;
  logic [23:0] o_dp_code;
  logic [23:0] i_dp_f;
  logic [23:0] o_word;
  logic o_word_valid;
  logic i_word_ready;
  logic o_busy;
  logic [CNT_W-1:0] o_word_cnt;
  modport slave (
    input i_mode, i_byte, i_byte_valid, i_last, i_dp_f, i_word_ready,
    output o_byte_ready, o_dp_a, o_dp_b, o_dp_c, o_dp_code, o_word, o_word_valid, o_busy, o_word_cnt
  );
  modport master (
    output i_mode, i_byte, i_byte_valid, i_last, i_dp_f, i_word_ready,
    input o_byte_ready, o_dp_a, o_dp_b, o_dp_c, o_dp_code, o_word, o_word_valid, o_busy, o_word_cnt
  );
endinterface

// File: rtl/shop_byte_packer.sv
// shop_byte_packer: packs up to three bytes LSB-first, padding the rest on i_last
module shop_byte_packer
  import shop_seq_pkg::*;
#(
  parameter logic [7:0] PAD_CHAR = PAD_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_accept,
  input  logic        i_last,
  input  logic [7:0]  i_byte,
  output logic [1:0]  o_idx,
  output logic [23:0] o_word,
  output logic        o_done
);
  logic [1:0] r_idx;
  logic [23:0] r_pack;
  logic [23:0] w_fill;
  // Current byte lands in its slot; slots above it read as padding
  always_comb begin
    w_fill = r_pack;
    for (int s = 0; s < 3; s++)
      w_fill[8*s +: 8] = (2'(s) == r_idx) ? i_byte : (2'(s) > r_idx) ? PAD_CHAR : r_pack[8*s +: 8];
  end
  assign o_done = i_accept && (i_last || r_idx == SLOT_HI);
  assign o_word = w_fill;
  assign o_idx = r_idx;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_idx <= SLOT_LO;
      r_pack <= '0;
    end else if (i_accept) begin
      r_idx <= o_done ? SLOT_LO : r_idx + 2'd1;
      r_pack <= o_done ? '0 : w_fill;
    end
  end
endmodule

// File: rtl/shop_seq_ctrl.sv
// shop_seq_ctrl: feeds packed words to shop_v, waits a settle window, hands off o_f
module shop_seq_ctrl
  import shop_seq_pkg::*;
#(
  parameter int SETTLE_CYC = 2,
  parameter logic [7:0] PAD_CHAR = PAD_DEFAULT,
  parameter int CNT_W = 16
) (
  input logic i_clk,
  input logic i_rst,
  shop_seq_ctrl_if.slave bus
);
  state_t r_state;
  logic [2:0] r_mode;
  logic [2:0] r_abc;
  logic [15:0] r_settle;
  logic [23:0] r_code;
  logic [23:0] r_word;
  logic r_valid;
  logic [CNT_W-1:0] r_cnt;
  logic w_accept;
  logic w_done;
  logic [1:0] w_idx;
  logic [23:0] w_pack;
  logic [2:0] w_mode;
  assign w_accept = bus.i_byte_valid && bus.o_byte_ready;
  // A one-byte word uses the mode sampled on that same byte
  assign w_mode = (w_idx == SLOT_LO) ? bus.i_mode : r_mode;
  shop_byte_packer #(.PAD_CHAR(PAD_CHAR)) u_packer (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_accept(w_accept),
    .i_last(bus.i_last),
    .i_byte(bus.i_byte),
    .o_idx(w_idx),
    .o_word(w_pack),
    .o_done(w_done)
  );
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= FILL;
      r_mode <= '0;
      r_abc <= '0;
      r_settle <= '0;
      r_code <= '0;
      r_word <= '0;
      r_valid <= 1'b0;
      r_cnt <= '0;
    end else begin
      if (w_accept && w_idx == SLOT_LO) r_mode <= bus.i_mode;
      case (r_state)
        FILL: if (w_done) begin
          r_code <= w_pack;
          r_abc <= w_mode;
          r_settle <= '0;
          r_state <= DRIVE;
        end
        DRIVE: if (r_settle == 16'(SETTLE_CYC - 1)) begin
          r_word <= bus.i_dp_f;
          r_valid <= 1'b1;
          r_state <= OUT;
        end else r_settle <= r_settle + 16'd1;
        OUT: if (bus.i_word_ready) begin
          r_valid <= 1'b0;
          r_cnt <= r_cnt + 1'b1;
          r_state <= FILL;
        end
        default: r_state <= FILL;
      endcase
    end
  end
  assign bus.o_byte_ready = (r_state == FILL) && !i_rst;
  assign bus.o_busy = (r_state != FILL) || (w_idx != SLOT_LO);
  assign bus.o_dp_a = r_abc[MODE_A];
  assign bus.o_dp_b = r_abc[MODE_B];
  assign bus.o_dp_c = r_abc[MODE_C];
  assign bus.o_dp_code = r_code;
  assign bus.o_word = r_word;
  assign bus.o_word_valid = r_valid;
  assign bus.o_word_cnt = r_cnt;
endmodule

// File: tb/tb_shop_seq_ctrl.sv
// tb_shop_seq_ctrl: directed checks of packing, settle latency, backpressure, reset and count wrap
module tb_shop_seq_ctrl;
  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  int exp_cnt = 0;
  shop_seq_ctrl_if #(.CNT_W(2)) bus ();
  shop_seq_ctrl #(.SETTLE_CYC(2), .PAD_CHAR(8'h20), .CNT_W(2)) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .bus(bus)
  );
  always #5 i_clk = ~i_clk;
  // Stand-in for shop_v: any fixed function of code and mode bits
  function automatic logic [23:0] shop_v_model(input logic [23:0] code, input logic [2:0] abc);
    return code ^ {8{abc}};
  endfunction
  assign bus.i_dp_f = shop_v_model(bus.o_dp_code, {bus.o_dp_c, bus.o_dp_b, bus.o_dp_a});
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic send_byte(input logic [7:0] b, input logic last, input logic [2:0] mode);
    int t;
    @(negedge i_clk);
    bus.i_byte = b;
    bus.i_last = last;
    bus.i_mode = mode;
    bus.i_byte_valid = 1'b1;
    t = 0;
    while (!bus.o_byte_ready && t < 50) begin
      @(negedge i_clk);
      t++;
    end
    if (t == 50) check("byte_ready_timeout", 0, 1);
    @(posedge i_clk);
    #1;
    bus.i_byte_valid = 1'b0;
    bus.i_last = 1'b0;
  endtask
  // After the final byte edge n: inputs on shop_v at n, result valid at n+2
  task automatic expect_word(input string tag, input logic [23:0] code, input logic [2:0] abc);
    check({tag, "_code"}, 32'(bus.o_dp_code), 32'(code));
    check({tag, "_abc"}, 32'({bus.o_dp_c, bus.o_dp_b, bus.o_dp_a}), 32'(abc));
    check({tag, "_busy"}, 32'(bus.o_busy), 1);
    check({tag, "_rdy_drive"}, 32'(bus.o_byte_ready), 0);
    @(posedge i_clk);
    #1;
    check({tag, "_valid_early"}, 32'(bus.o_word_valid), 0);
    check({tag, "_abc_hold"}, 32'({bus.o_dp_c, bus.o_dp_b, bus.o_dp_a}), 32'(abc));
    @(posedge i_clk);
    #1;
    check({tag, "_valid"}, 32'(bus.o_word_valid), 1);
    check({tag, "_word"}, 32'(bus.o_word), 32'(shop_v_model(code, abc)));
  endtask
  task automatic handshake(input string tag);
    @(negedge i_clk);
    bus.i_word_ready = 1'b1;
    @(posedge i_clk);
    #1;
    bus.i_word_ready = 1'b0;
    exp_cnt = (exp_cnt + 1) % 4;
    check({tag, "_valid_drop"}, 32'(bus.o_word_valid), 0);
    check({tag, "_cnt"}, 32'(bus.o_word_cnt), 32'(exp_cnt));
    check({tag, "_code_hold"}, 32'(bus.o_dp_code), 32'(bus.o_dp_code));
  endtask
  initial begin
    logic [23:0] held;
    bus.i_mode = '0;
    bus.i_byte = '0;
    bus.i_byte_valid = 1'b0;
    bus.i_last = 1'b0;
    bus.i_word_ready = 1'b0;
    #2;
    check("rst_ready", 32'(bus.o_byte_ready), 0);
    check("rst_valid", 32'(bus.o_word_valid), 0);
    check("rst_code", 32'(bus.o_dp_code), 0);
    check("rst_word", 32'(bus.o_word), 0);
    check("rst_cnt", 32'(bus.o_word_cnt), 0);
    check("rst_busy", 32'(bus.o_busy), 0);
    @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    check("fill_ready", 32'(bus.o_byte_ready), 1);
    send_byte(8'h41, 1'b0, 3'b111);
    check("busy_partial", 32'(bus.o_busy), 1);
    send_byte(8'h42, 1'b0, 3'b111);
    send_byte(8'h43, 1'b0, 3'b111);
    expect_word("full", 24'h434241, 3'b111);
    handshake("full");
    send_byte(8'h41, 1'b1, 3'b010);
    expect_word("partial", 24'h202041, 3'b010);
    handshake("partial");
    send_byte(8'h61, 1'b0, 3'b001);
    send_byte(8'h62, 1'b0, 3'b110);
    send_byte(8'h63, 1'b1, 3'b110);
    expect_word("mode", 24'h636261, 3'b001);
    held = bus.o_word;
    @(negedge i_clk);
    bus.i_byte = 8'h44;
    bus.i_mode = 3'b010;
    bus.i_byte_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge i_clk);
      #1;
      check("bp_word", 32'(bus.o_word), 32'(held));
      check("bp_ready", 32'(bus.o_byte_ready), 0);
      check("bp_valid", 32'(bus.o_word_valid), 1);
    end
    handshake("bp");
    check("bp_ready_after", 32'(bus.o_byte_ready), 1);
    check("bp_busy_idle", 32'(bus.o_busy), 0);
    @(posedge i_clk);
    #1;
    bus.i_byte_valid = 1'b0;
    check("bp_slot0_taken", 32'(bus.o_busy), 1);
    send_byte(8'h45, 1'b0, 3'b101);
    send_byte(8'h46, 1'b0, 3'b101);
    expect_word("bp_next", 24'h464544, 3'b010);
    handshake("bp_next");
    send_byte(8'h43, 1'b0, 3'b011);
    send_byte(8'h42, 1'b0, 3'b011);
    send_byte(8'h43, 1'b0, 3'b011);
    check("rst_pre_code", 32'(bus.o_dp_code), 32'h434243);
    i_rst = 1'b1;
    #1;
    check("rst_mid_code", 32'(bus.o_dp_code), 0);
    check("rst_mid_abc", 32'({bus.o_dp_c, bus.o_dp_b, bus.o_dp_a}), 0);
    check("rst_mid_ready", 32'(bus.o_byte_ready), 0);
    check("rst_mid_cnt", 32'(bus.o_word_cnt), 0);
    exp_cnt = 0;
    @(negedge i_clk);
    i_rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge i_clk);
      #1;
      check("rst_no_valid", 32'(bus.o_word_valid), 0);
    end
    send_byte(8'h41, 1'b0, 3'b100);
    send_byte(8'h42, 1'b0, 3'b100);
    send_byte(8'h44, 1'b0, 3'b100);
    expect_word("post_rst", 24'h444241, 3'b100);
    handshake("post_rst");
    exp_cnt = 0;
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    for (int w = 0; w < 8; w++) begin
      send_byte(8'h30 + 8'(w), 1'b0, 3'(w));
      send_byte(8'h31, 1'b1, 3'b000);
      expect_word("wrap", {8'h20, 8'h31, 8'h30 + 8'(w)}, 3'(w));
      handshake("wrap");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/shop_seq_ctrl.md
Name: shop_seq_ctrl

Overview:
Sequencer for the shop_v combinational ASCII datapath. It accepts a byte stream over valid/ready and packs each group of three characters into one 24-bit word, with the first byte in [7:0]. It drives the packed word and the latched a/b/c mode bits into shop_v, holds them stable for a settle window, then captures o_f and presents it as a 24-bit result word with backpressure.

Parameters:
SETTLE_CYC, 2, cycles the datapath inputs are held before o_f is captured; legal range is 1 or more.
PAD_CHAR, 8'h20, character written into unfilled slots on a partial (i_last) word.
CNT_W, 16, width of the completed-word counter.

Ports:
i_clk  in  1  clock; all state changes on the rising edge.
i_rst  in  1  reset; asynchronous, active-high.
i_mode  in  3  {c,b,a} mode for shop_v; sampled when the first byte of a word is accepted.
i_byte  in  8  input ASCII character.
i_byte_valid  in  1  i_byte (and i_last) is valid.
i_last  in  1  accepted byte ends the current word; remaining slots are padded.
o_byte_ready  out  1  controller can accept a byte.
o_dp_a  out  1  drives shop_v .a
o_dp_b  out  1  drives shop_v .b
o_dp_c  out  1  drives shop_v .c
o_dp_code  out  24  drives shop_v .i_code
i_dp_f  in  24  from shop_v .o_f
o_word  out  24  captured result.
o_word_valid  out  1  o_word is valid.
i_word_ready  in  1  downstream accepts o_word.
o_busy  out  1  high in DRIVE or OUT, or while a partial word is held in FILL.
o_word_cnt  out  CNT_W  count of results handed off; wraps.

Behaviour:
- Reset (asynchronous, immediate):
  - state = FILL, slot index = 0, pack register = 0, latched mode = 0.
  - o_dp_code = 0, o_dp_a/b/c = 0, o_word = 0, o_word_valid = 0, o_word_cnt = 0, o_busy = 0.
  - o_byte_ready is forced 0 while i_rst is high.
- States: FILL -> DRIVE -> OUT -> FILL.
- FILL:
  - o_byte_ready = 1. A byte is accepted when i_byte_valid and o_byte_ready are both high.
  - Accepted byte goes to slot idx: 0 -> [7:0], 1 -> [15:8], 2 -> [23:16].
  - On acceptance at idx = 0, i_mode is latched.
  - Go to DRIVE when idx = 2 is accepted, or when any byte is accepted with i_last = 1. Unfilled higher slots get PAD_CHAR. idx returns to 0.
  - i_last is ignored when i_byte_valid is low.
  - Changes to i_mode at idx 1 or 2 have no effect on the current word.
- DRIVE:
  - On entry edge, o_dp_code = packed word and o_dp_a/b/c = latched mode. Both hold unchanged until the next DRIVE entry, including through OUT and FILL.
  - Settle counter runs SETTLE_CYC cycles. On the edge ending the last one, o_word <= i_dp_f and state -> OUT.
- OUT:
  - o_word_valid = 1, and o_word holds stable until i_word_ready = 1.
  - On the handshake edge: o_word_valid -> 0, o_word_cnt increments modulo 2^CNT_W, state -> FILL.
  - o_word_valid stays high indefinitely if i_word_ready stays low.
- Latency: final byte accepted on edge n. Datapath inputs change at n. o_f is captured at edge n+SETTLE_CYC. o_word_valid is high from n+SETTLE_CYC, so the minimum word period is SETTLE_CYC+4 cycles with i_word_ready held high.
- o_byte_ready is 0 in DRIVE and OUT, so no byte is lost or overwritten.
- Reset mid-word or mid-DRIVE: the partial or in-flight word is discarded with no output.

Decomposition:
- Package shop_seq_pkg holds:
  - State enum: FILL, DRIVE, OUT.
  - Slot constants: SLOT_LO = 0, SLOT_MID = 1, SLOT_HI = 2.
  - Default PAD_CHAR.
  - Mode bit indices: MODE_A = 0, MODE_B = 1, MODE_C = 2.
- Sub-module shop_byte_packer holds the slot index, pack register, padding and "word complete" output. The FSM, settle counter, output register and word counter stay in the top.

Test Plan:
- Full word, mode 3'b111, bytes 41, 42, 43, SETTLE_CYC = 2 -> o_dp_code = 24'h434241 and a = b = c = 1 for 2 cycles. o_word equals the bench's shop_v model output for 24'h434241. o_word_cnt = 1.
- Partial word: byte 41 with i_last = 1 -> o_dp_code = 24'h202041; a single result is produced.
- Mode change: i_mode = 3'b001 at the first byte, 3'b110 at the second and third -> o_dp_a = 1, o_dp_b = 0, o_dp_c = 0 throughout DRIVE.
- Backpressure: i_word_ready held 0 for 5 cycles in OUT while i_byte_valid = 1 with byte 44 -> o_word stable, o_byte_ready = 0, and 44 is accepted only after the handshake, as slot 0 of the next word.
- Reset: i_rst pulsed during DRIVE of 24'h434243 -> o_word_valid never rises for that word, all outputs are 0, and the next three bytes 41, 42, 44 produce 24'h444241.
- Counter wrap: CNT_W = 2, eight complete words -> o_word_cnt sequence 1, 2, 3, 0, 1, 2, 3, 0.
